mac_row_feeder: RTL and testbench

- West-edge driver for one row of mixed-precision MAC tiles. It generates the `in_w`/`inst_w` stream that the first tile consumes.
- Sequences a kernel-load phase (weights, `inst_w`=01), then an execute phase (activations, `inst_w`=10), then a drain.
- Sources are two valid/ready streams, one for weights and one for activations.
- Handles the 2b mode, where each tile takes two weights (lane 0 then lane 1) and each activation is 2-bit unsigned.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_row_feeder.sv | 125 ++++++++++++
 tb/tb_mac_row_feeder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC row feeder and its tile row.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXEC  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int BW_DEF     = 4;
    localparam int COL_DEF    = 8;
    localparam int LEN_BW_DEF = 8;

endpackage

// File: rtl/mac_row_feeder.sv
// West-edge feeder for one MAC tile row: kernel load, execute, then drain.
// state | meaning
// IDLE  | waiting for start; outputs hold
// LOAD  | accepting nw weights (col, or 2*col in 2b mode)
// EXEC  | accepting exec_len activations
// DRAIN | col+1 idle cycles so the last word ripples through the row
// DONE  | one-cycle done pulse
module mac_row_feeder
    import mac_pkg::*;
#(
    parameter int bw     = BW_DEF,
    parameter int col    = COL_DEF,
    parameter int len_bw = LEN_BW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_2b_in,
    input  logic [len_bw-1:0] exec_len,
    input  logic [bw-1:0]     wgt_data,
    input  logic              wgt_valid,
    output logic              wgt_ready,
    input  logic [bw-1:0]     act_data,
    input  logic              act_valid,
    output logic              act_ready,
    output logic [bw-1:0]     out_w,
    output logic [1:0]        inst_w,
    output logic              mode_2b,
    output logic              busy,
    output logic              done
);

    localparam int LW = $clog2(2*col + 1);
    localparam int DW = $clog2(col + 2);

    state_t            state, state_nx;
    logic [LW-1:0]     load_cnt;
    logic [len_bw-1:0] exec_cnt;
    logic [len_bw-1:0] exec_len_q;
    logic [DW-1:0]     drain_cnt;
    logic [LW-1:0]     nw;
    logic              wgt_hs, act_hs;
    logic [bw-1:0]     out_w_nx;
    logic [1:0]        inst_w_nx;

    // Readies depend on state only so the upstream never sees a valid-to-ready path.
    assign wgt_ready = (state == LOAD);
    assign act_ready = (state == EXEC);
    assign wgt_hs    = wgt_valid & wgt_ready;
    assign act_hs    = act_valid & act_ready;
    assign nw        = mode_2b ? LW'(2*col) : LW'(col);

    always_comb begin
        state_nx  = state;
        out_w_nx  = out_w;
        inst_w_nx = INST_NOP;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                if (wgt_hs) begin
                    out_w_nx  = wgt_data;
                    inst_w_nx = INST_LOAD;
                    if (load_cnt + LW'(1) == nw)
                        state_nx = (exec_len_q == '0) ? DRAIN : EXEC;
                end
            end
            EXEC: begin
                if (act_hs) begin
                    out_w_nx = act_data;
                    // 2b activations are unsigned; the tile expects the upper bits clear.
                    if (mode_2b) out_w_nx[bw-1:2] = '0;
                    inst_w_nx = INST_EXEC;
                    if (exec_cnt + len_bw'(1) == exec_len_q) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                out_w_nx = '0;
                if (drain_cnt == DW'(col)) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_w      <= '0;
            inst_w     <= INST_NOP;
            mode_2b    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            exec_len_q <= '0;
            load_cnt   <= '0;
            exec_cnt   <= '0;
            drain_cnt  <= '0;
        end else begin
            state  <= state_nx;
            out_w  <= out_w_nx;
            inst_w <= inst_w_nx;
            busy   <= (state_nx != IDLE);
            done   <= (state_nx == DONE);
            if (state == IDLE && start) begin
                mode_2b    <= mode_2b_in;
                exec_len_q <= exec_len;
            end
            if (state_nx != state) begin
                load_cnt  <= '0;
                exec_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                if (wgt_hs)         load_cnt  <= load_cnt + LW'(1);
                if (act_hs)         exec_cnt  <= exec_cnt + len_bw'(1);
                if (state == DRAIN) drain_cnt <= drain_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Bench for mac_row_feeder: job table, hand sequences and random jobs against a stream model.
module tb_mac_row_feeder;
    import mac_pkg::*;

    localparam int COL = 8;

    logic       clk, reset, start, mode_2b_in;
    logic [7:0] exec_len;
    logic [3:0] wgt_data, act_data, out_w;
    logic       wgt_valid, wgt_ready, act_valid, act_ready;
    logic [1:0] inst_w;
    logic       mode_2b, busy, done;

    mac_row_feeder #(.bw(4), .col(COL), .len_bw(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_2b_in(mode_2b_in),
        .exec_len(exec_len), .wgt_data(wgt_data), .wgt_valid(wgt_valid),
        .wgt_ready(wgt_ready), .act_data(act_data), .act_valid(act_valid),
        .act_ready(act_ready), .out_w(out_w), .inst_w(inst_w),
        .mode_2b(mode_2b), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int elen;
        int wp;
        int ap;
        int exp_loads;
        int exp_execs;
        int exp_busy;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         job_mode = 1'b0;
    logic [3:0] prev_out = 4'h0;
    logic [3:0] wq[$];
    logic [3:0] aq[$];
    logic [3:0] ld_q[$];
    logic [3:0] ex_q[$];
    int wi, ai, nw_cur, elen_cur;
    int done_cnt, busy_cnt, done_cyc, start_cyc, first_ld_cyc;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0: always valid, 1: toggles 1,0,1,0, 2: random (~75% valid)
    function automatic bit pat(input int p, input int k);
        if (p == 0) return 1'b1;
        if (p == 1) return (k % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One clock: note handshakes on the inputs as driven, then check the registered outputs.
    task automatic cycle(output bit hw, output bit ha);
        bit         rs, feed;
        logic [3:0] dw, da, exp_o;
        rs   = reset;
        hw   = wgt_valid && wgt_ready;
        ha   = act_valid && act_ready;
        dw   = wgt_data;
        da   = act_data;
        feed = (wi < nw_cur) || (ai < elen_cur);
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            chk("rst_inst", int'(inst_w), 0);
            chk("rst_out", int'(out_w), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_mode", int'(mode_2b), 0);
            chk("rst_readies", int'({wgt_ready, act_ready}), 0);
        end else begin
            if (hw) begin
                chk("load_inst", int'(inst_w), 1);
                chk("load_out", int'(out_w), int'(dw));
                ld_q.push_back(out_w);
            end else if (ha) begin
                exp_o = job_mode ? {2'b00, da[1:0]} : da;
                chk("exec_inst", int'(inst_w), 2);
                chk("exec_out", int'(out_w), int'(exp_o));
                ex_q.push_back(out_w);
            end else begin
                chk("nop_inst", int'(inst_w), 0);
                chk("nop_out", int'(out_w), feed ? int'(prev_out) : 0);
            end
            chk("mode_out", int'(mode_2b), int'(job_mode));
            chk("ready_excl", int'(wgt_ready && act_ready), 0);
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_out = out_w;
    endtask

    task automatic run_job(input bit m, input int elen, input int wp, input int ap,
                           input int rst_at, input int poke_at);
        bit hw, ha;
        int k, nw, w_end, a_end, last;
        nw = m ? 2*COL : COL;
        while (wq.size() < nw)   wq.push_back(4'($urandom));
        while (aq.size() < elen) aq.push_back(4'($urandom));
        nw_cur = nw; elen_cur = elen; wi = 0; ai = 0;
        ld_q.delete(); ex_q.delete();
        done_cnt = 0; busy_cnt = 0; done_cyc = -1; w_end = -1; a_end = -1; first_ld_cyc = -1;

        start = 1'b1; mode_2b_in = m; exec_len = 8'(elen);
        wgt_valid = pat(wp, 0); act_valid = pat(ap, 0);
        wgt_data = wq[0]; act_data = 4'($urandom);
        job_mode = m;
        cycle(hw, ha);
        start_cyc = cyc;
        start = 1'b0;

        k = 0;
        while (done_cnt == 0 && k < 600) begin
            wgt_valid = pat(wp, k);
            act_valid = pat(ap, k);
            wgt_data  = (wi < wq.size()) ? wq[wi] : 4'($urandom);
            act_data  = (ai < aq.size()) ? aq[ai] : 4'($urandom);
            if (poke_at > 0 && wi == poke_at) begin
                start = 1'b1; mode_2b_in = ~m; exec_len = 8'(elen + 3);
            end
            if (rst_at >= 0 && wi == nw && ai == rst_at) reset = 1'b1;
            cycle(hw, ha);
            start = 1'b0; mode_2b_in = 1'b0;
            if (reset) begin
                reset = 1'b0;
                job_mode = 1'b0;
                return;
            end
            if (hw) begin
                wi++;
                if (wi == 1)  first_ld_cyc = cyc;
                if (wi == nw) w_end = cyc;
            end
            if (ha) begin
                ai++;
                if (ai == elen) a_end = cyc;
            end
            k++;
        end
        chk("done_seen", done_cnt, 1);

        wgt_valid = 1'b1; act_valid = 1'b1;
        cycle(hw, ha);
        chk("done_pulse_once", done_cnt, 1);
        chk("busy_after_done", int'(busy), 0);

        chk("n_loads", ld_q.size(), nw);
        for (int i = 0; i < nw && i < ld_q.size(); i++)
            chk("load_order", int'(ld_q[i]), int'(wq[i]));
        chk("n_execs", ex_q.size(), elen);
        for (int i = 0; i < elen && i < ex_q.size(); i++)
            chk("exec_order", int'(ex_q[i]), m ? int'(aq[i][1:0]) : int'(aq[i]));
        last = (elen == 0) ? w_end : a_end;
        chk("drain_len", done_cyc - last, COL + 1);
        chk("busy_len", busy_cnt, done_cyc - start_cyc + 1);
    endtask

    vec_t vt[6];
    bit   hw0, ha0;

    initial begin
        vt[0] = '{m: 1'b0, elen: 3, wp: 0, ap: 0, exp_loads: 8,  exp_execs: 3, exp_busy: 21};
        vt[1] = '{m: 1'b1, elen: 5, wp: 0, ap: 0, exp_loads: 16, exp_execs: 5, exp_busy: 31};
        vt[2] = '{m: 1'b0, elen: 0, wp: 0, ap: 0, exp_loads: 8,  exp_execs: 0, exp_busy: 18};
        vt[3] = '{m: 1'b0, elen: 4, wp: 1, ap: 1, exp_loads: 8,  exp_execs: 4, exp_busy: -1};
        vt[4] = '{m: 1'b1, elen: 2, wp: 2, ap: 2, exp_loads: 16, exp_execs: 2, exp_busy: -1};
        vt[5] = '{m: 1'b0, elen: 1, wp: 0, ap: 0, exp_loads: 8,  exp_execs: 1, exp_busy: 19};

        reset = 1'b1; start = 1'b0; mode_2b_in = 1'b0; exec_len = 8'd0;
        wgt_data = 4'h0; act_data = 4'h0; wgt_valid = 1'b0; act_valid = 1'b0;
        nw_cur = 0; elen_cur = 0; wi = 0; ai = 0;
        repeat (3) cycle(hw0, ha0);
        reset = 1'b0;
        cycle(hw0, ha0);

        for (int i = 0; i < 6; i++) begin
            wq.delete(); aq.delete();
            if (i == 1) begin
                for (int v = 1; v <= 15; v++) wq.push_back(4'(v));
                wq.push_back(4'h8);
                aq.push_back(4'hE);
            end
            run_job(vt[i].m, vt[i].elen, vt[i].wp, vt[i].ap, -1, -1);
            chk("tbl_loads", ld_q.size(), vt[i].exp_loads);
            chk("tbl_execs", ex_q.size(), vt[i].exp_execs);
            if (vt[i].exp_busy >= 0) begin
                chk("tbl_busy", busy_cnt, vt[i].exp_busy);
                chk("tbl_first_load", first_ld_cyc - start_cyc, 1);
            end
        end

        // Activation 0xE in 2b mode must surface as 0x2.
        wq.delete(); aq.delete();
        aq.push_back(4'hE);
        run_job(1'b1, 1, 0, 0, -1, -1);
        chk("act_2b_e", ex_q.size() > 0 ? int'(ex_q[0]) : -1, 2);

        // Start re-pulsed mid-LOAD with the other mode must not disturb the job.
        wq.delete(); aq.delete();
        for (int i = 0; i < 4; i++) aq.push_back(4'hC + 4'(i));
        run_job(1'b0, 4, 0, 0, -1, 3);
        chk("poke_busy", busy_cnt, 8 + 4 + COL + 1 + 1);

        // Reset on the third EXEC cycle, then a fresh job must load from zero.
        wq.delete(); aq.delete();
        run_job(1'b0, 5, 0, 0, 2, -1);
        chk("post_rst_busy", int'(busy), 0);
        wgt_valid = 1'b1; act_valid = 1'b1;
        cycle(hw0, ha0);
        chk("post_rst_idle_inst", int'(inst_w), 0);
        wq.delete(); aq.delete();
        run_job(1'b1, 2, 0, 0, -1, -1);

        for (int j = 0; j < 10; j++) begin
            wq.delete(); aq.delete();
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 12),
                    $urandom_range(0, 2), $urandom_range(0, 2), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
